// File: rtl/divider_sn.sv
// divider_sn -- iterative non-restoring divider, signed or unsigned per operation.
//
// Each operation takes a fixed number of cycles: a start accepted at clock edge k
// gives a done pulse after edge k+WIDTH+1. A divide by zero gives done after
// edge k+1. Results and flags stay valid until the next done. The flags are
// cleared when the next start is accepted.
//
// Ports:
//   clk        rising-edge clock
//   n_rst      asynchronous active-low reset
//   start      division request; only sampled while idle
//   is_signed  1 = two's-complement operands, 0 = unsigned (captured with start)
//   dividend   dividend (captured with start)
//   divisor    divisor  (captured with start)
//   busy       high while a division is in progress
//   done       one-cycle pulse when quotient/remainder/flags are updated
//   quotient   quotient, truncated toward zero
//   remainder  remainder, with the same sign as the dividend
//   div_zero   divisor was zero (quotient = all ones, remainder = raw dividend)
//   overflow   signed MIN / -1 (quotient = MIN, remainder = 0)
module divider_sn #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nx;

  // Operation context captured at start
  logic             mode_signed;
  logic             sign_dvd;
  logic             sign_dvs;
  logic [WIDTH-1:0] dvd_raw;
  logic [WIDTH-1:0] dvs_mag;
  logic             zero_pend;
  logic             ovf_pend;

  // Iteration state: partial remainder (one guard bit) and quotient shift register
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] qsh;
  logic [CNT_W-1:0] cnt;

  // Combinational helpers
  logic             accept;
  logic             in_neg_dvd;
  logic             in_neg_dvs;
  logic [WIDTH-1:0] in_dvd_mag;
  logic [WIDTH-1:0] in_dvs_mag;
  logic             in_zero;
  logic             in_ovf;
  logic [WIDTH:0]   dvs_ext;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH:0]   acc_it;
  logic [WIDTH-1:0] q_it;
  logic [WIDTH-1:0] rem_mag;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  assign busy   = (state != IDLE);
  assign accept = (state == IDLE) && start;

  // Operand conditioning for capture
  always_comb begin
    in_neg_dvd = is_signed & dividend[WIDTH-1];
    in_neg_dvs = is_signed & divisor[WIDTH-1];
    in_dvd_mag = in_neg_dvd ? ('0 - dividend) : dividend;
    in_dvs_mag = in_neg_dvs ? ('0 - divisor)  : divisor;
    in_zero    = (divisor == '0);
    in_ovf     = is_signed && (dividend == MIN_VAL) && (divisor == '1);
  end

  // One non-restoring step: shift {acc, qsh} left, then subtract or add the
  // divisor depending on the sign of the partial remainder before the shift.
  // The new quotient bit is the inverted sign of the result.
  always_comb begin
    dvs_ext = {1'b0, dvs_mag};
    acc_sh  = {acc[WIDTH-1:0], qsh[WIDTH-1]};
    if (acc[WIDTH]) begin
      acc_it = acc_sh + dvs_ext;
    end else begin
      acc_it = acc_sh - dvs_ext;
    end
    q_it = {qsh[WIDTH-2:0], ~acc_it[WIDTH]};
  end

  // Final correction and sign application. A negative partial remainder is
  // restored by adding the divisor back; only the low WIDTH bits are needed
  // because the corrected remainder is always below the divisor magnitude.
  always_comb begin
    rem_mag = acc[WIDTH-1:0] + (acc[WIDTH] ? dvs_mag : '0);
    neg_q   = mode_signed & (sign_dvd ^ sign_dvs);
    neg_r   = mode_signed & sign_dvd;
    q_res   = neg_q ? ('0 - qsh)     : qsh;
    r_res   = neg_r ? ('0 - rem_mag) : rem_mag;
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = in_zero ? FIX : CALC;
        end
      end
      CALC: begin
        // The counter reaches 0 on this edge, after the last iteration.
        if (cnt == CNT_W'(1)) begin
          state_nx = FIX;
        end
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_signed <= 1'b0;
      sign_dvd    <= 1'b0;
      sign_dvs    <= 1'b0;
      dvd_raw     <= '0;
      dvs_mag     <= '0;
      zero_pend   <= 1'b0;
      ovf_pend    <= 1'b0;
      acc         <= '0;
      qsh         <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_zero    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mode_signed <= is_signed;
        sign_dvd    <= dividend[WIDTH-1];
        sign_dvs    <= divisor[WIDTH-1];
        dvd_raw     <= dividend;
        dvs_mag     <= in_dvs_mag;
        zero_pend   <= in_zero;
        ovf_pend    <= in_ovf;
        acc         <= '0;
        qsh         <= in_dvd_mag;
        cnt         <= CNT_W'(WIDTH);
        div_zero    <= 1'b0;
        overflow    <= 1'b0;
      end else if (state == CALC) begin
        acc <= acc_it;
        qsh <= q_it;
        cnt <= cnt - CNT_W'(1);
      end else if (state == FIX) begin
        done <= 1'b1;
        if (zero_pend) begin
          quotient  <= '1;
          remainder <= dvd_raw;
          div_zero  <= 1'b1;
          overflow  <= 1'b0;
        end else begin
          // MIN / -1 falls out of the magnitude path as MIN with remainder 0;
          // it only needs flagging.
          quotient  <= q_res;
          remainder <= r_res;
          div_zero  <= 1'b0;
          overflow  <= ovf_pend;
        end
      end
    end
  end

endmodule

// File: tb/tb_divider_sn.sv
// tb_divider_sn -- directed and randomised checks for divider_sn.
// A 16-bit instance takes the directed vectors, the handshake cases and the reset cases.
// Instances with WIDTH 4, 8 and 32 run randomised operands against a behavioural reference.
module tb_divider_sn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst;
  logic        n_rst_s;
  logic        start;
  logic        is_signed;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;
  logic        overflow;

  int n_checks    = 0;
  int n_errors    = 0;
  int sweeps_done = 0;

  divider_sn #(.WIDTH(16)) u_dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Truncating division at width w. This models the arithmetic result directly,
  // without the iteration.
  function automatic void ref_div(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic sgn, output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output logic ov);
    longint m, sa, sb, tq, tr;
    m  = (longint'(1) << w) - 1;
    dz = 1'b0;
    ov = 1'b0;
    q  = '0;
    r  = '0;
    if (b == 32'd0) begin
      q  = 32'(m);
      r  = a;
      dz = 1'b1;
    end else begin
      if (sgn) begin
        sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        ov = (sa == -(longint'(1) << (w - 1))) && (sb == -1);
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      tq = sa / sb;
      tr = sa % sb;
      q  = 32'(tq & m);
      r  = 32'(tr & m);
    end
  endfunction

  // Drive operands and start from the current time, through one rising edge.
  // The operands are then scrambled, because they only need to be valid in the start cycle.
  task automatic launch(input logic sgn, input logic [15:0] a, input logic [15:0] b);
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    is_signed = ~sgn;
    dividend  = 16'h5A5A;
    divisor   = 16'hA5A5;
  endtask

  // Count edges from the start edge, which is edge 1, up to the edge after which done is high.
  // Also count the cycles in which busy is high. A lat of 0 means a timeout.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    for (int e = 1; e <= 64; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = e + 1;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  typedef struct {
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, bc, ndone;
    vecs[0] = '{1'b0, 16'd1000, 16'd7,  16'd142,  16'd6,    1'b0, 1'b0, 18};
    vecs[1] = '{1'b1, 16'hFFF9, 16'd2,  16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 18};
    vecs[2] = '{1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 18};
    vecs[3] = '{1'b1, 16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0, 1'b0, 18};
    vecs[4] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 18};
    vecs[5] = '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 18};
    vecs[6] = '{1'b0, 16'd5,    16'd9,  16'd0,    16'd5,    1'b0, 1'b0, 18};
    vecs[7] = '{1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 2};
    vecs[8] = '{1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 2};
    vecs[9] = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 18};

    n_rst     = 1'b0;
    n_rst_s   = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    check("rst_q",    64'(quotient),  64'd0);
    check("rst_r",    64'(remainder), 64'd0);
    check("rst_busy", 64'(busy),      64'd0);
    check("rst_done", 64'(done),      64'd0);
    check("rst_dz",   64'(div_zero),  64'd0);
    check("rst_ov",   64'(overflow),  64'd0);
    @(negedge clk);
    n_rst   = 1'b1;
    n_rst_s = 1'b1;

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_done(lat, bc);
      check($sformatf("v%0d_q", i),   64'(quotient),  64'(vecs[i].q));
      check($sformatf("v%0d_r", i),   64'(remainder), 64'(vecs[i].r));
      check($sformatf("v%0d_dz", i),  64'(div_zero),  64'(vecs[i].dz));
      check($sformatf("v%0d_ov", i),  64'(overflow),  64'(vecs[i].ov));
      check($sformatf("v%0d_lat", i), 64'(lat),       64'(vecs[i].lat));
      if (i == 0) begin
        check("v0_busy_cycles", 64'(bc), 64'd17);
        @(posedge clk);
        #1;
        check("v0_done_pulse", 64'(done), 64'd0);
        check("v0_q_held", 64'(quotient), 64'd142);
      end
    end

    // A start pulse with new operands during CALC must be ignored
    @(negedge clk);
    launch(1'b0, 16'd1000, 16'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b1;
    dividend  = 16'd50;
    divisor   = 16'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    check("ign_q",   64'(quotient),  64'd142);
    check("ign_r",   64'(remainder), 64'd6);
    check("ign_lat", 64'(lat),       64'd13);

    // A start asserted in the done cycle is accepted
    @(negedge clk);
    launch(1'b0, 16'd100, 16'd3);
    wait_done(lat, bc);
    check("b2b1_q", 64'(quotient),  64'd33);
    check("b2b1_r", 64'(remainder), 64'd1);
    launch(1'b1, 16'hFF9C, 16'd7);
    wait_done(lat, bc);
    check("b2b2_q",   64'(quotient),  64'hFFF2);
    check("b2b2_r",   64'(remainder), 64'hFFFE);
    check("b2b2_lat", 64'(lat),       64'd18);

    // Reset during CALC aborts the division
    @(negedge clk);
    launch(1'b0, 16'd1000, 16'd7);
    repeat (5) @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("arst_q",    64'(quotient),  64'd0);
    check("arst_r",    64'(remainder), 64'd0);
    check("arst_busy", 64'(busy),      64'd0);
    check("arst_done", 64'(done),      64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    ndone = 0;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("arst_no_done", 64'(ndone), 64'd0);
    check("arst_idle",    64'(busy),  64'd0);

    // Wait for the width sweeps, with a cycle budget
    for (int i = 0; i < 90000 && sweeps_done < 3; i++) @(posedge clk);
    check("sweeps_complete", 64'(sweeps_done), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int W = (gi == 0) ? 4 : (gi == 1) ? 8 : 32;

    logic         sst;
    logic         ssg;
    logic [W-1:0] sdd;
    logic [W-1:0] sdv;
    logic         sbz;
    logic         sdn;
    logic [W-1:0] sq;
    logic [W-1:0] sr;
    logic         sdz;
    logic         sov;

    divider_sn #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .n_rst     (n_rst_s),
      .start     (sst),
      .is_signed (ssg),
      .dividend  (sdd),
      .divisor   (sdv),
      .busy      (sbz),
      .done      (sdn),
      .quotient  (sq),
      .remainder (sr),
      .div_zero  (sdz),
      .overflow  (sov)
    );

    initial begin
      logic [31:0] mask, ra, rb, eq, er;
      logic        edz, eov;
      int          sel, lat;
      mask = (W == 32) ? 32'hFFFF_FFFF : ((32'd1 << W) - 32'd1);
      sst  = 1'b0;
      ssg  = 1'b0;
      sdd  = '0;
      sdv  = '0;
      @(posedge n_rst_s);
      for (int n = 0; n < 1000; n++) begin
        ra  = $urandom;
        rb  = $urandom;
        sel = $urandom_range(0, 15);
        if (sel == 0) rb = 32'd0;
        else if (sel == 1) begin ra = 32'd1 << (W - 1); rb = 32'hFFFF_FFFF; end
        else if (sel == 2) rb = 32'd1;
        else if (sel == 3) ra = 32'hFFFF_FFFF;
        else if (sel == 4) rb = rb >> (W - 2);
        ra = ra & mask;
        rb = rb & mask;
        @(negedge clk);
        ssg = 1'($urandom_range(0, 1));
        sst = 1'b1;
        sdd = ra[W-1:0];
        sdv = rb[W-1:0];
        @(posedge clk);
        #1;
        sst = 1'b0;
        check($sformatf("w%0d_busy", W), 64'(sbz), 64'd1);
        lat = 0;
        for (int e = 1; e <= W + 8; e++) begin
          @(posedge clk);
          #1;
          if (sdn) begin
            lat = e + 1;
            break;
          end
        end
        ref_div(W, ra, rb, ssg, eq, er, edz, eov);
        check($sformatf("w%0d_q", W),   64'(sq),  64'(eq));
        check($sformatf("w%0d_r", W),   64'(sr),  64'(er));
        check($sformatf("w%0d_dz", W),  64'(sdz), 64'(edz));
        check($sformatf("w%0d_ov", W),  64'(sov), 64'(eov));
        check($sformatf("w%0d_lat", W), 64'(lat), edz ? 64'd2 : 64'(W + 2));
      end
      sweeps_done++;
    end
  end

endmodule
